// File: rtl/fib_ram_engine_if.sv
// Bus bundle for fib_ram_engine: run control, status and the inspection read port.
// The master side drives requests; the slave side is the engine.
interface fib_ram_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              start;
    logic              mode;
    logic [DATA_W-1:0] seed0;
    logic [DATA_W-1:0] seed1;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] tmp;
    logic              ovf;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output start, mode, seed0, seed1, count, rd_addr,
        input  busy, done, tmp, ovf, rd_data
    );

    modport slave (
        input  start, mode, seed0, seed1, count, rd_addr,
        output busy, done, tmp, ovf, rd_data
    );
endinterface

// File: rtl/fib_ram_engine.sv
// Generalised Fibonacci generator that builds the sequence in an internal RAM,
// fetching both operands back from the RAM for every new term.
module fib_ram_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    fib_ram_engine_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] TWO_N   = (ADDR_W + 1)'(2);
    localparam logic [ADDR_W:0] ONE_N   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        W0,
        W1,
        RDA,
        RDB,
        WR,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mode_q;
    logic [DATA_W-1:0] seed0_q;
    logic [DATA_W-1:0] seed1_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   i_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] eng_rdata;
    logic [DATA_W-1:0] tmp_q;
    logic              ovf_q;
    logic [DATA_W-1:0] rd_q;

    logic [ADDR_W:0]   n_eff;
    logic [ADDR_W:0]   i_next;
    logic [ADDR_W:0]   i_m1;
    logic [ADDR_W:0]   i_m2;
    logic [DATA_W:0]   sum_full;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] eng_raddr;

    // Requested length clamped to the legal range [2, DEPTH]
    always_comb begin
        n_eff = bus.count;
        if (bus.count < TWO_N) begin
            n_eff = TWO_N;
        end else if (bus.count > DEPTH_N) begin
            n_eff = DEPTH_N;
        end
    end

    assign i_next   = i_q + ONE_N;
    assign i_m1     = i_q - ONE_N;
    assign i_m2     = i_q - TWO_N;
    assign sum_full = {1'b0, op_a} + {1'b0, eng_rdata} + {{DATA_W{1'b0}}, mode_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        eng_raddr  = '0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = W0;
                end
            end
            W0: begin
                we         = 1'b1;
                waddr      = '0;
                wdata      = seed0_q;
                state_next = W1;
            end
            W1: begin
                we         = 1'b1;
                waddr      = ADDR_W'(1);
                wdata      = seed1_q;
                state_next = (n_q == TWO_N) ? DONE : RDA;
            end
            RDA: begin
                eng_raddr  = i_m2[ADDR_W-1:0];
                state_next = RDB;
            end
            RDB: begin
                eng_raddr  = i_m1[ADDR_W-1:0];
                state_next = WR;
            end
            WR: begin
                we         = 1'b1;
                waddr      = i_q[ADDR_W-1:0];
                wdata      = sum_full[DATA_W-1:0];
                state_next = (i_next == n_q) ? DONE : RDA;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // RAM contents deliberately survive reset; only the ports are registered
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        eng_rdata <= mem[eng_raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[bus.rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 1'b0;
            seed0_q <= '0;
            seed1_q <= '0;
            n_q     <= TWO_N;
            i_q     <= '0;
            op_a    <= '0;
            tmp_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode_q  <= bus.mode;
                        seed0_q <= bus.seed0;
                        seed1_q <= bus.seed1;
                        n_q     <= n_eff;
                        ovf_q   <= 1'b0;
                    end
                end
                W0: begin
                    tmp_q <= seed0_q;
                end
                W1: begin
                    tmp_q <= seed1_q;
                    i_q   <= TWO_N;
                end
                RDB: begin
                    op_a <= eng_rdata;
                end
                WR: begin
                    tmp_q <= sum_full[DATA_W-1:0];
                    ovf_q <= ovf_q | sum_full[DATA_W];
                    i_q   <= i_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.tmp     = tmp_q;
    assign bus.ovf     = ovf_q;
    assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_fib_ram_engine.sv
// Randomised and directed checks of fib_ram_engine against a plain-arithmetic
// sequence model; instance a is 32-bit/64-deep, instance b is 8-bit/16-deep.
module tb_fib_ram_engine;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fib_ram_engine_if #(.DATA_W(32), .ADDR_W(6)) bus_a ();
    fib_ram_engine_if #(.DATA_W(8),  .ADDR_W(4)) bus_b ();

    fib_ram_engine #(.DATA_W(32), .ADDR_W(6)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    fib_ram_engine #(.DATA_W(8),  .ADDR_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    longint unsigned exp_seq [64];
    bit              exp_ovf;
    int              exp_n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sequence from its definition: clamp N, then sum with wrap and note any carry
    task automatic build_model(input int w, input bit mode, input longint unsigned s0,
                               input longint unsigned s1, input int count, input int depth);
        longint unsigned mask;
        longint unsigned full;
        mask = (64'd1 << w) - 64'd1;
        exp_n = (count < 2) ? 2 : (count > depth) ? depth : count;
        exp_seq[0] = s0 & mask;
        exp_seq[1] = s1 & mask;
        exp_ovf = 1'b0;
        for (int k = 2; k < exp_n; k++) begin
            full = exp_seq[k-1] + exp_seq[k-2] + longint'(mode);
            if (full > mask) exp_ovf = 1'b1;
            exp_seq[k] = full & mask;
        end
    endtask

    function automatic logic [63:0] get_tmp(input int sel);
        return (sel == 0) ? {32'd0, bus_a.tmp} : {56'd0, bus_b.tmp};
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? bus_a.done : bus_b.done;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    function automatic logic get_ovf(input int sel);
        return (sel == 0) ? bus_a.ovf : bus_b.ovf;
    endfunction

    function automatic logic [63:0] get_rd(input int sel);
        return (sel == 0) ? {32'd0, bus_a.rd_data} : {56'd0, bus_b.rd_data};
    endfunction

    task automatic set_inputs(input int sel, input bit mode, input longint unsigned s0,
                              input longint unsigned s1, input int count, input bit st);
        if (sel == 0) begin
            bus_a.mode  = mode;
            bus_a.seed0 = s0[31:0];
            bus_a.seed1 = s1[31:0];
            bus_a.count = 7'(count);
            bus_a.start = st;
        end else begin
            bus_b.mode  = mode;
            bus_b.seed0 = s0[7:0];
            bus_b.seed1 = s1[7:0];
            bus_b.count = 5'(count);
            bus_b.start = st;
        end
    endtask

    // Returns on the negedge after the start-accepting edge
    task automatic drive_start(input int sel, input bit mode, input longint unsigned s0,
                               input longint unsigned s1, input int count);
        @(negedge clk);
        set_inputs(sel, mode, s0, s1, count, 1'b1);
        @(negedge clk);
        if (sel == 0) bus_a.start = 1'b0; else bus_b.start = 1'b0;
    endtask

    task automatic wait_done(input int sel, input bit glitch, output int lat);
        lat = -1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (get_done(sel)) begin
                lat = cyc + 1;
                break;
            end
            if (glitch && cyc == 4) set_inputs(sel, ~bus_a.mode, 64'd77, 64'd99, 3, 1'b1);
            if (glitch && cyc == 5) set_inputs(sel, bus_a.mode, 64'd5, 64'd6, 40, 1'b0);
            @(negedge clk);
        end
    endtask

    task automatic read_word(input int sel, input int addr, output logic [63:0] data);
        @(negedge clk);
        if (sel == 0) bus_a.rd_addr = 6'(addr); else bus_b.rd_addr = 4'(addr);
        @(negedge clk);
        data = get_rd(sel);
    endtask

    task automatic run_and_check(input int sel, input string tag, input bit mode,
                                 input longint unsigned s0, input longint unsigned s1,
                                 input int count, input bit glitch);
        int lat;
        logic [63:0] word;
        build_model((sel == 0) ? 32 : 8, mode, s0, s1, count, (sel == 0) ? 64 : 16);
        drive_start(sel, mode, s0, s1, count);
        check($sformatf("%s busy", tag), 64'(get_busy(sel)), 64'd1);
        wait_done(sel, glitch, lat);
        check($sformatf("%s latency", tag), 64'(lat), 64'(3 + 3 * (exp_n - 2)));
        check($sformatf("%s tmp", tag), get_tmp(sel), exp_seq[exp_n-1]);
        check($sformatf("%s ovf", tag), 64'(get_ovf(sel)), 64'(exp_ovf));
        @(negedge clk);
        check($sformatf("%s idle", tag), {62'd0, get_busy(sel), get_done(sel)}, 64'd0);
        for (int k = 0; k < exp_n; k++) begin
            read_word(sel, k, word);
            check($sformatf("%s mem[%0d]", tag, k), word, exp_seq[k]);
        end
    endtask

    initial begin
        int lat;
        bit seen;
        logic [63:0] word;
        longint unsigned r0;
        longint unsigned r1;

        rst_n = 1'b0;
        set_inputs(0, 1'b0, 64'd0, 64'd0, 0, 1'b0);
        set_inputs(1, 1'b0, 64'd0, 64'd0, 0, 1'b0);
        bus_a.rd_addr = '0;
        bus_b.rd_addr = '0;
        #1;
        check("reset a outputs", {get_tmp(0)[31:0], 29'd0, get_busy(0), get_done(0), get_ovf(0)}, 64'd0);
        check("reset a rd_data", get_rd(0), 64'd0);
        check("reset b outputs", {get_tmp(1)[31:0], 29'd0, get_busy(1), get_done(1), get_ovf(1)}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_and_check(0, "fib10", 1'b0, 64'd1, 64'd1, 10, 1'b0);
        check("fib10 tmp const", get_tmp(0), 64'd55);
        read_word(0, 5, word);
        check("fib10 rd5", word, 64'd8);
        read_word(0, 9, word);
        check("fib10 rd9", word, 64'd55);

        run_and_check(0, "plus1", 1'b1, 64'd1, 64'd1, 6, 1'b0);
        read_word(0, 5, word);
        check("plus1 rd5", word, 64'd15);

        run_and_check(0, "count0", 1'b0, 64'd123, 64'd456, 0, 1'b0);
        check("count0 tmp", get_tmp(0), 64'd456);

        run_and_check(1, "b clamp31", 1'b0, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), 31, 1'b0);

        // 8-bit wrap: ovf must still be clear right after 233 lands at address 12
        drive_start(1, 1'b0, 64'd1, 64'd1, 14);
        seen = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (get_tmp(1) == 64'd233) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("b wrap saw 233", 64'(seen), 64'd1);
        check("b wrap ovf at 233", 64'(get_ovf(1)), 64'd0);
        wait_done(1, 1'b0, lat);
        check("b wrap done", 64'(lat > 0), 64'd1);
        check("b wrap ovf done", 64'(get_ovf(1)), 64'd1);
        check("b wrap tmp", get_tmp(1), 64'd121);
        read_word(1, 12, word);
        check("b wrap rd12", word, 64'd233);
        read_word(1, 13, word);
        check("b wrap rd13", word, 64'd121);

        run_and_check(0, "restart ignored", 1'b0, 64'($urandom), 64'($urandom), 20, 1'b1);

        for (int t = 0; t < 6; t++) begin
            run_and_check(0, $sformatf("rand a%0d", t), 1'($urandom_range(0, 1)),
                          64'($urandom), 64'($urandom), int'($urandom_range(0, 80)), 1'b0);
        end
        for (int t = 0; t < 3; t++) begin
            run_and_check(1, $sformatf("rand b%0d", t), 1'($urandom_range(0, 1)),
                          64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)),
                          int'($urandom_range(0, 31)), 1'b0);
        end

        // Abort a long run with an asynchronous reset between clock edges
        r0 = 64'($urandom);
        r1 = 64'($urandom);
        build_model(32, 1'b0, r0, r1, 30, 64);
        drive_start(0, 1'b0, r0, r1, 30);
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(get_busy(0)), 64'd0);
        check("abort done", 64'(get_done(0)), 64'd0);
        check("abort tmp", get_tmp(0), 64'd0);
        check("abort ovf", 64'(get_ovf(0)), 64'd0);
        check("abort rd_data", get_rd(0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            read_word(0, k, word);
            check($sformatf("abort kept mem[%0d]", k), word, exp_seq[k]);
        end
        run_and_check(0, "after abort", 1'b1, 64'($urandom), 64'($urandom), 12, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
